// File: rtl/pipeline_pkg.sv
// Shared pipeline types: next-PC selector classes and the IF/ID register layout used by fetch and decode.
package pipeline_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        EX_REDIRECT,
        HOLD,
        PREDICT,
        SEQ
    } npc_sel_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            pred_taken;
        logic            valid;
    } if_id_t;

    function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
        if_id_t b;
        b.instr      = nop;
        b.pc         = '0;
        b.pc_plus4   = '0;
        b.pred_taken = 1'b0;
        b.valid      = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, stall holds, otherwise captures the fetched word.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= if_id_bubble(NOP);
        end else if (flush) begin
            q <= if_id_bubble(NOP);
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register with prioritized next-PC selection, IF/ID register and redirect/stall counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int                    DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP        = NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic [DATA_WIDTH-1:0] PCBPU,
    input  logic                  PCBPUSrc,
    input  logic                  flushBranch,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  JumpE,
    input  logic [DATA_WIDTH-1:0] InstrMemRD,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] InstrF,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  PredTakenD,
    output logic                  ValidD,
    output logic [31:0]           RedirectCnt,
    output logic [31:0]           StallCnt
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    logic                  ex_redirect;
    npc_sel_t              npc_sel;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] next_pc_raw;
    logic [DATA_WIDTH-1:0] next_pc;
    if_id_t                if_id_d;
    if_id_t                if_id_q;

    assign ex_redirect = flushBranch | JumpE;
    assign pc_plus4    = PCF + PC_STEP;
    assign InstrF      = InstrMemRD;

    // An EX redirect discards the stalled (younger) instruction, so it outranks StallF.
    always_comb begin
        if (ex_redirect)   npc_sel = EX_REDIRECT;
        else if (StallF)   npc_sel = HOLD;
        else if (PCBPUSrc) npc_sel = PREDICT;
        else               npc_sel = SEQ;
    end

    // NOTE: every path of a combinational block assigns its outputs, so no latch is inferred.
    always_comb begin
        next_pc_raw = pc_plus4;
        unique case (npc_sel)
            EX_REDIRECT: next_pc_raw = flushBranch ? PCBPU : PCTargetE;
            HOLD:        next_pc_raw = PCF;
            PREDICT:     next_pc_raw = PCBPU;
            SEQ:         next_pc_raw = pc_plus4;
            default:     next_pc_raw = pc_plus4;
        endcase
        next_pc = {next_pc_raw[DATA_WIDTH-1:2], 2'b00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) PCF <= RESET_PC;
        else     PCF <= next_pc;
    end

    always_comb begin
        if_id_d.instr      = InstrMemRD;
        if_id_d.pc         = PCF;
        if_id_d.pc_plus4   = pc_plus4;
        if_id_d.pred_taken = PCBPUSrc & ~ex_redirect;
        if_id_d.valid      = 1'b1;
    end

    if_id_reg #(.NOP(NOP)) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .stall (StallD),
        .flush (FlushD | ex_redirect),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign InstrD     = if_id_q.instr;
    assign PCD        = if_id_q.pc;
    assign PCPlus4D   = if_id_q.pc_plus4;
    assign PredTakenD = if_id_q.pred_taken;
    assign ValidD     = if_id_q.valid;

    // Performance counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RedirectCnt <= '0;
            StallCnt    <= '0;
        end else begin
            if (ex_redirect && RedirectCnt != 32'hFFFF_FFFF)
                RedirectCnt <= RedirectCnt + 32'd1;
            if (StallF && !ex_redirect && StallCnt != 32'hFFFF_FFFF)
                StallCnt <= StallCnt + 32'd1;
        end
    end

endmodule
